video_out_fetch: RTL and testbench

Wishbone read master that fetches one frame of 8-bit greyscale pixels from RAM and pushes them, as 32-bit words (4 pixels/word), into the video-out FIFO.
The processor gives the frame base address through the control/data registers. Fetching starts on a rising edge of wb_reg_ctr[0].
At end of frame the block raises an interrupt for 3 cycles. It is the read-side counterpart of the video-in store path.

---
 rtl/video_out_fetch.sv | 231 +++++++++++++++++++++++
 tb/tb_video_out_fetch.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_out_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : video_out_fetch
//  Purpose  : Wishbone read master that streams one frame of 8-bit greyscale
//             pixels (packed 4 per 32-bit word) from RAM into the video-out
//             FIFO, in fixed-length bursts, and flags end of frame.
//  Revision : 1.0  initial release
// ============================================================================
module video_out_fetch #(
    parameter int P_WIDTH     = 640,
    parameter int P_HEIGHT    = 480,
    parameter int BURST_WORDS = 16
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_ctr,
    input  logic [31:0] wb_reg_data,
    input  logic        fifo_space_ok,
    output logic        fifo_w_en,
    output logic [31:0] fifo_data,
    output logic        interrupt,
    output logic        bus_err,
    output logic        busy,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic [31:0] p_wb_DAT_I,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I
);

    localparam int              NWORDS      = P_WIDTH * P_HEIGHT / 4;
    localparam int              BW          = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [19:0]     C_LAST_WORD = 20'(NWORDS - 1);
    localparam logic [BW-1:0]   C_LAST_BEAT = BW'(BURST_WORDS - 1);
    localparam logic [1:0]      C_DONE_LAST = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SPACE = 2'd1,
        S_READ       = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_ctr0_q;
    logic            w_new_addr;
    logic            r_pend;
    logic [31:0]     r_pend_base;
    logic [31:0]     r_base;
    logic [19:0]     r_word_cnt;
    logic [BW-1:0]   r_burst_cnt;
    logic [1:0]      r_done_cnt;

    logic            r_bus;
    logic [31:0]     r_adr;
    logic            r_fifo_w_en;
    logic [31:0]     r_fifo_data;
    logic            r_irq;
    logic            r_bus_err;
    logic            r_busy;

    logic            w_start;
    logic            w_burst_go;
    logic            w_ack;
    logic            w_err;
    logic            w_done_exit;
    logic            w_last_beat;
    logic            w_last_word;
    logic            w_unused;

    // Only bit 0 of the control register carries meaning here.
    assign w_unused    = &{1'b0, wb_reg_ctr[31:1]};

    assign w_new_addr  = wb_reg_ctr[0] & ~r_ctr0_q;
    assign w_last_beat = (r_burst_cnt == C_LAST_BEAT);
    assign w_last_word = (r_word_cnt == C_LAST_WORD);

    // Next-state decode plus one-cycle event strobes used by the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_burst_go   = 1'b0;
        w_ack        = 1'b0;
        w_err        = 1'b0;
        w_done_exit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_new_addr || r_pend) begin
                    w_start      = 1'b1;
                    w_state_next = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (fifo_space_ok) begin
                    w_burst_go   = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                // An error terminates the frame even if ACK arrives with it.
                if (p_wb_ERR_I) begin
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                end else if (p_wb_ACK_I) begin
                    w_ack = 1'b1;
                    if (w_last_word) begin
                        w_state_next = S_DONE;
                    end else if (w_last_beat) begin
                        w_state_next = S_WAIT_SPACE;
                    end
                end
            end
            S_DONE: begin
                if (r_done_cnt == C_DONE_LAST) begin
                    w_done_exit  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start-edge detection and the one-deep pending request for a busy block.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_ctr0_q    <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_base <= 32'd0;
        end else begin
            r_ctr0_q <= wb_reg_ctr[0];
            if (w_new_addr && (r_state != S_IDLE)) begin
                r_pend      <= 1'b1;
                r_pend_base <= wb_reg_data;
            end else if (w_start) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Frame datapath: counters, bus address, FIFO write and status flags.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_base      <= 32'd0;
            r_word_cnt  <= 20'd0;
            r_burst_cnt <= '0;
            r_done_cnt  <= 2'd0;
            r_bus       <= 1'b0;
            r_adr       <= 32'd0;
            r_fifo_w_en <= 1'b0;
            r_fifo_data <= 32'd0;
            r_irq       <= 1'b0;
            r_bus_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_fifo_w_en <= 1'b0;

            if (w_start) begin
                // A fresh edge in IDLE wins over an older pending request.
                r_base      <= w_new_addr ? wb_reg_data : r_pend_base;
                r_word_cnt  <= 20'd0;
                r_burst_cnt <= '0;
                r_busy      <= 1'b1;
                r_bus_err   <= 1'b0;
            end

            if (w_burst_go) begin
                r_bus <= 1'b1;
                r_adr <= r_base + {10'd0, r_word_cnt, 2'b00};
            end

            if (w_ack) begin
                r_fifo_w_en <= 1'b1;
                r_fifo_data <= p_wb_DAT_I;
                r_adr       <= r_adr + 32'd4;
                r_word_cnt  <= w_last_word ? 20'd0 : r_word_cnt + 20'd1;
                if (w_last_beat) begin
                    r_burst_cnt <= '0;
                    r_bus       <= 1'b0;
                end else begin
                    r_burst_cnt <= r_burst_cnt + BW'(1);
                end
                if (w_last_word) begin
                    r_irq      <= 1'b1;
                    r_done_cnt <= 2'd0;
                end
            end

            if (w_err) begin
                r_bus       <= 1'b0;
                r_bus_err   <= 1'b1;
                r_busy      <= 1'b0;
                r_burst_cnt <= '0;
            end

            if (r_state == S_DONE) begin
                r_done_cnt <= r_done_cnt + 2'd1;
                if (w_done_exit) begin
                    r_irq  <= 1'b0;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign p_wb_STB_O = r_bus;
    assign p_wb_CYC_O = r_bus;
    assign p_wb_WE_O  = 1'b0;
    assign p_wb_SEL_O = 4'hF;
    assign p_wb_ADR_O = r_adr;
    assign fifo_w_en  = r_fifo_w_en;
    assign fifo_data  = r_fifo_data;
    assign interrupt  = r_irq;
    assign bus_err    = r_bus_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_video_out_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_out_fetch
//  Purpose  : Self-checking bench for video_out_fetch: a Wishbone slave model
//             with random data/wait states, a frame-level reference model and
//             a per-cycle compare process.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_out_fetch;

    localparam int TB_W      = 64;
    localparam int TB_H      = 16;
    localparam int BURST     = 16;
    localparam int NW        = TB_W * TB_H / 4;
    localparam int BUDGET    = 20000;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] wb_reg_ctr = 32'd0;
    logic [31:0] wb_reg_data = 32'd0;
    logic        fifo_space_ok = 1'b1;
    logic        fifo_w_en;
    logic [31:0] fifo_data;
    logic        interrupt;
    logic        bus_err;
    logic        busy;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i = 32'd0;
    logic        ack = 1'b0;
    logic        err = 1'b0;

    video_out_fetch #(
        .P_WIDTH     (TB_W),
        .P_HEIGHT    (TB_H),
        .BURST_WORDS (BURST)
    ) dut (
        .clk           (clk),
        .nRST          (nRST),
        .wb_reg_ctr    (wb_reg_ctr),
        .wb_reg_data   (wb_reg_data),
        .fifo_space_ok (fifo_space_ok),
        .fifo_w_en     (fifo_w_en),
        .fifo_data     (fifo_data),
        .interrupt     (interrupt),
        .bus_err       (bus_err),
        .busy          (busy),
        .p_wb_STB_O    (stb),
        .p_wb_CYC_O    (cyc),
        .p_wb_WE_O     (we),
        .p_wb_SEL_O    (sel),
        .p_wb_ADR_O    (adr),
        .p_wb_DAT_I    (dat_i),
        .p_wb_ACK_I    (ack),
        .p_wb_ERR_I    (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level reference model state.
    logic        mon_en = 1'b0;
    logic        slow = 1'b0;
    logic        model_active = 1'b0;
    logic [31:0] model_base = 32'd0;
    int          model_word = 0;
    logic        model_pend = 1'b0;
    logic [31:0] model_pend_base = 32'd0;
    int          err_at_word = -1;

    // Compare-process bookkeeping.
    logic        wr_pending = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        exp_bus_drop = 1'b0;
    logic        prev_stb = 1'b0;
    int          burst_acks = 0;
    int          wait_left = 0;
    int          irq_len = 0;
    int          frames_done = 0;
    int          n_writes = 0;
    int          burst_starts = 0;
    int          cyc_hi = 0;
    logic [31:0] last_burst_start_adr = 32'd0;
    logic [31:0] frame_first_adr = 32'd0;
    logic [31:0] last_ack_adr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL timeout_%s: got no event, expected it within %0d cycles", name, BUDGET);
    endtask

    // Per-cycle compare process; also acts as the Wishbone slave.
    initial begin
        logic [31:0] rdat;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("sel", {28'd0, sel}, 32'hF);
                chk("we", {31'd0, we}, 32'd0);
                chk("cyc_eq_stb", {31'd0, cyc}, {31'd0, stb});

                if (wr_pending) begin
                    chk("fifo_w_en", {31'd0, fifo_w_en}, 32'd1);
                    chk("fifo_data", fifo_data, wr_data);
                end else begin
                    chk("fifo_w_en_quiet", {31'd0, fifo_w_en}, 32'd0);
                end
                if (fifo_w_en) n_writes++;
                wr_pending = 1'b0;

                if (exp_bus_drop) chk("burst_drop", {31'd0, stb}, 32'd0);
                exp_bus_drop = 1'b0;
                if (cyc) cyc_hi++;

                if (interrupt) begin
                    if (irq_len == 0)
                        chk("irq_at_end", {31'd0, model_active && (model_word == NW)}, 32'd1);
                    irq_len++;
                end else if (irq_len != 0) begin
                    chk("irq_len", irq_len, 32'd3);
                    chk("busy_after_done", {31'd0, busy}, 32'd0);
                    frames_done++;
                    irq_len = 0;
                    if (model_pend) begin
                        model_pend = 1'b0;
                        model_base = model_pend_base;
                        model_word = 0;
                        burst_acks = 0;
                    end else begin
                        model_active = 1'b0;
                    end
                end

                ack = 1'b0;
                err = 1'b0;
                if (stb) begin
                    if (!prev_stb) begin
                        burst_starts++;
                        last_burst_start_adr = adr;
                        if (model_word == 0) frame_first_adr = adr;
                    end
                    chk("stb_expected", {31'd0, model_active && (model_word < NW)}, 32'd1);
                    chk("adr", adr, model_base + 32'(model_word * 4));
                    if (wait_left > 0) begin
                        wait_left--;
                    end else begin
                        rdat = $urandom;
                        dat_i = rdat;
                        ack = 1'b1;
                        wait_left = slow ? int'($urandom_range(0, 3)) : 0;
                        if (model_word == err_at_word) begin
                            err = 1'b1;
                            err_at_word = -1;
                            model_active = 1'b0;
                            burst_acks = 0;
                            exp_bus_drop = 1'b1;
                        end else begin
                            wr_pending = 1'b1;
                            wr_data = rdat;
                            last_ack_adr = adr;
                            model_word++;
                            burst_acks++;
                            if (burst_acks == BURST) begin
                                burst_acks = 0;
                                exp_bus_drop = 1'b1;
                            end
                        end
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    // Stray responses with no strobe must be ignored.
                    dat_i = $urandom;
                    ack = 1'b1;
                end
                prev_stb = stb;
            end
        end
    end

    task automatic start_frame(input logic [31:0] base);
        @(negedge clk);
        wb_reg_data = base;
        wb_reg_ctr = 32'h1;
        if (model_active) begin
            model_pend = 1'b1;
            model_pend_base = base;
        end else begin
            model_active = 1'b1;
            model_base = base;
            model_word = 0;
            burst_acks = 0;
        end
        @(negedge clk);
        wb_reg_ctr = 32'h0;
    endtask

    task automatic wait_word(input int w);
        int n = 0;
        while (!(model_active && model_word >= w) && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        if (n >= BUDGET) timeout("word");
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        if (n >= BUDGET) timeout("frame");
    endtask

    task automatic wait_inactive();
        int n = 0;
        while (model_active && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        if (n >= BUDGET) timeout("abort");
    endtask

    initial begin
        int b0;
        int w0;
        int c0;
        int f0;

        // Reset values while nRST is held low.
        #7;
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_sel", {28'd0, sel}, 32'hF);
        chk("rst_adr", adr, 32'd0);
        chk("rst_wen", {31'd0, fifo_w_en}, 32'd0);
        chk("rst_flags", {29'd0, interrupt, bus_err, busy}, 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Full frame, zero wait states.
        b0 = burst_starts;
        w0 = n_writes;
        start_frame(32'h1000_0000);
        wait_frames(1);
        chk("t1_bursts", burst_starts - b0, NW / BURST);
        chk("t1_writes", n_writes - w0, NW);
        chk("t1_first_adr", frame_first_adr, 32'h1000_0000);
        chk("t1_last_adr", last_ack_adr, 32'h1000_03FC);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // FIFO back-pressure before the third burst.
        start_frame(32'h1000_0000);
        wait_word(20);
        fifo_space_ok = 1'b0;
        wait_word(32);
        repeat (3) @(posedge clk);
        c0 = cyc_hi;
        w0 = n_writes;
        repeat (50) @(posedge clk);
        chk("t2_cyc_stalled", cyc_hi - c0, 32'd0);
        chk("t2_writes_stalled", n_writes - w0, 32'd0);
        @(negedge clk);
        fifo_space_ok = 1'b1;
        wait_word(33);
        chk("t2_resume_adr", last_burst_start_adr, 32'h1000_0080);
        wait_frames(2);

        // Random wait states.
        slow = 1'b1;
        f0 = frames_done;
        start_frame(32'hFFFF_FF00);
        wait_frames(f0 + 1);
        chk("t3_wrap_last_adr", last_ack_adr, 32'h0000_02FC);

        // Bus error coinciding with ACK on word 100.
        err_at_word = 100;
        f0 = frames_done;
        start_frame(32'h1000_0000);
        wait_inactive();
        repeat (4) @(posedge clk);
        chk("t4_bus_err", {31'd0, bus_err}, 32'd1);
        chk("t4_cyc", {31'd0, cyc}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_no_irq", frames_done - f0, 32'd0);
        chk("t4_written", last_ack_adr, 32'h1000_018C);
        start_frame(32'h3000_0000);
        repeat (2) @(posedge clk);
        chk("t4_err_cleared", {31'd0, bus_err}, 32'd0);
        wait_frames(f0 + 1);
        chk("t4_refetch_adr", frame_first_adr, 32'h3000_0000);

        // Second start while a frame is running is queued.
        slow = 1'b0;
        f0 = frames_done;
        start_frame(32'h1000_0000);
        wait_word(50);
        start_frame(32'h2000_0000);
        wait_frames(f0 + 2);
        chk("t5_pend_first_adr", frame_first_adr, 32'h2000_0000);
        chk("t5_pend_last_adr", last_ack_adr, 32'h2000_03FC);

        // Asynchronous reset in the middle of a burst.
        start_frame(32'h1000_0000);
        wait_word(40);
        @(posedge clk);
        #2;
        chk("t6_stb_before", {31'd0, stb}, 32'd1);
        nRST = 1'b0;
        mon_en = 1'b0;
        ack = 1'b0;
        err = 1'b0;
        #1;
        chk("t6_async_bus", {30'd0, stb, cyc}, 32'd0);
        chk("t6_async_flags", {28'd0, fifo_w_en, interrupt, bus_err, busy}, 32'd0);
        chk("t6_async_adr", adr, 32'd0);
        chk("t6_async_sel", {28'd0, sel}, 32'hF);
        model_active = 1'b0;
        model_pend = 1'b0;
        wr_pending = 1'b0;
        exp_bus_drop = 1'b0;
        prev_stb = 1'b0;
        burst_acks = 0;
        wait_left = 0;
        irq_len = 0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        mon_en = 1'b1;
        c0 = cyc_hi;
        repeat (30) @(posedge clk);
        chk("t6_quiet_cyc", cyc_hi - c0, 32'd0);
        chk("t6_quiet_busy", {31'd0, busy}, 32'd0);
        f0 = frames_done;
        start_frame(32'h4000_0000);
        wait_frames(f0 + 1);
        chk("t6_restart_adr", frame_first_adr, 32'h4000_0000);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
